writeback_arbiter: RTL and testbench

// - Write-side driver of the integer register file: collects results from NUM_SRC execution units
//   (ALU, mul/div, load unit), picks one per cycle, drives the register-file write port.
// - One registered write per cycle; per-source valid/ready handshake back-pressures the losers.
// - Sits between execute/memory stages and the integer register file write port.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/writeback_arbiter_if.sv | 30 +++
 rtl/wb_arbiter_core.sv | 48 ++++
 rtl/writeback_arbiter.sv | 91 +++++++++
 tb/tb_writeback_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared writeback definitions for the integer register-file write path.
// Holds the data width, the register-address width, the number of result
// sources and the fixed index assigned to each execution unit.
// Ports: none (package).
// Configuration macro consumed by users of this package: WB_ROUND_ROBIN_EN.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_WB_SRC = 3;

    localparam int WB_SRC_ALU    = 0;
    localparam int WB_SRC_MULDIV = 1;
    localparam int WB_SRC_LSU    = 2;

    // Width of an index into n sources; a single source still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback bus between the result sources and the register-file write port.
// Source side: src_valid_i, src_rd_i, src_data_i in; src_ready_o back.
// Write-port side: rd_o, write_data_o, reg_write_o, retired_o.
// Modports: slave = arbiter, master = sources / register-file model.
interface writeback_arbiter_if #(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 32
);

    logic [NUM_SRC-1:0]      src_valid_i;
    logic [5*NUM_SRC-1:0]    src_rd_i;
    logic [XLEN*NUM_SRC-1:0] src_data_i;
    logic [NUM_SRC-1:0]      src_ready_o;
    logic [4:0]              rd_o;
    logic [XLEN-1:0]         write_data_o;
    logic                    reg_write_o;
    logic [CNT_W-1:0]        retired_o;

    modport slave (
        input  src_valid_i, src_rd_i, src_data_i,
        output src_ready_o, rd_o, write_data_o, reg_write_o, retired_o
    );

    modport master (
        output src_valid_i, src_rd_i, src_data_i,
        input  src_ready_o, rd_o, write_data_o, reg_write_o, retired_o
    );

endinterface

// File: rtl/wb_arbiter_core.sv
// Grant logic for the writeback arbiter: valid vector (+ round-robin pointer)
// in, one-hot grant plus its binary index out. Purely combinational.
// Ports:
//   valid_i       per-source result valid
//   ptr_i         round-robin start index (only with WB_ROUND_ROBIN_EN)
//   grant_o       one-hot grant, zero when nothing valid
//   grant_idx_o   binary index of the granted source
//   grant_valid_o any grant this cycle
// Macro WB_ROUND_ROBIN_EN: defined -> round-robin from ptr_i, undefined ->
// fixed priority with index 0 highest.
module wb_arbiter_core
    import wb_pkg::*;
#(
    parameter  int NUM_SRC = NUM_WB_SRC,
    localparam int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] valid_i,
`ifdef WB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]   ptr_i,
`endif
    output logic [NUM_SRC-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef WB_ROUND_ROBIN_EN
            // Search starts at the pointer and wraps modulo NUM_SRC.
            cand = IDX_W'((int'(ptr_i) + i) % NUM_SRC);
`else
            cand = IDX_W'(i);
`endif
            if (!grant_valid_o && valid_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: picks one of NUM_SRC execution-unit results per cycle
// and drives the integer register-file write port one cycle later.
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_i   asynchronous active-high reset
//   wb      writeback_arbiter_if.slave: src_valid_i/src_rd_i/src_data_i in,
//           src_ready_o (one-hot grant), rd_o, write_data_o, reg_write_o,
//           retired_o out
// Macro WB_ROUND_ROBIN_EN: defined -> round-robin arbitration with a pointer
// register; undefined -> fixed priority, no pointer state.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter  int NUM_SRC = NUM_WB_SRC,
    parameter  int XLEN    = wb_pkg::XLEN,
    parameter  int CNT_W   = 32,
    localparam int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    writeback_arbiter_if.slave  wb
);

    logic [NUM_SRC-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  do_write;

    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       data_q;
    logic                  we_q;
    logic [CNT_W-1:0]      retired_q;

`ifdef WB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]      rr_ptr_q;
`endif

    wb_arbiter_core #(
        .NUM_SRC       (NUM_SRC)
    ) u_core (
        .valid_i       (wb.src_valid_i),
`ifdef WB_ROUND_ROBIN_EN
        .ptr_i         (rr_ptr_q),
`endif
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign sel_rd   = wb.src_rd_i[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign sel_data = wb.src_data_i[int'(grant_idx)*XLEN +: XLEN];

    // A grant targeting x0 is still consumed, but never reaches the port.
    assign do_write = grant_valid && (sel_rd != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q      <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            retired_q <= '0;
        end else begin
            we_q <= do_write;
            if (do_write) begin
                rd_q      <= sel_rd;
                data_q    <= sel_data;
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

`ifdef WB_ROUND_ROBIN_EN
    // Pointer moves just past the winner so it becomes lowest priority next.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (grant_valid) begin
            rr_ptr_q <= (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end
`endif

    assign wb.src_ready_o  = grant;
    assign wb.rd_o         = rd_q;
    assign wb.write_data_o = data_q;
    assign wb.reg_write_o  = we_q;
    assign wb.retired_o    = retired_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    localparam int NS = 3;
    localparam int XL = 32;
    localparam int CW = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    writeback_arbiter_if #(.NUM_SRC(NS), .XLEN(XL), .CNT_W(CW)) wb ();

    writeback_arbiter #(.NUM_SRC(NS), .XLEN(XL), .CNT_W(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wb    (wb)
    );

    typedef struct packed {
        logic          we;
        logic [4:0]    rd;
        logic [XL-1:0] data;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    int            m_ptr = 0;
    logic [CW-1:0] m_ret = '0;

    function automatic logic [NS-1:0] model_grant(input logic [NS-1:0] v);
        logic [NS-1:0] g;
        int k;
        g = '0;
        for (int i = 0; i < NS; i++) begin
`ifdef WB_ROUND_ROBIN_EN
            k = (m_ptr + i) % NS;
`else
            k = i;
`endif
            if (g == '0 && v[k]) g[k] = 1'b1;
        end
        return g;
    endfunction

    task automatic drive_src(input int k, input logic v, input logic [4:0] rd, input logic [XL-1:0] d);
        wb.src_valid_i[k]         = v;
        wb.src_rd_i[k*5 +: 5]     = rd;
        wb.src_data_i[k*XL +: XL] = d;
    endtask

    // Model the grant for the currently driven inputs and queue the write
    // the port should show after the next rising edge.
    task automatic predict(output logic [NS-1:0] g);
        exp_t e;
        g = model_grant(wb.src_valid_i);
        e = '0;
        for (int k = 0; k < NS; k++) begin
            if (g[k]) begin
                e.rd   = wb.src_rd_i[k*5 +: 5];
                e.data = wb.src_data_i[k*XL +: XL];
                e.we   = (e.rd != 5'd0);
                if (e.we) m_ret = m_ret + CW'(1);
                m_ptr = (k + 1) % NS;
            end
        end
        e.ret = m_ret;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        wb.src_valid_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        m_ptr = 0;
        m_ret = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        wb.src_valid_i = '0;
        wb.src_rd_i    = '0;
        wb.src_data_i  = '0;
        rst_i = 1'b1;
        #12;
        total++;
        if (wb.reg_write_o !== 1'b0 || wb.retired_o !== '0 || wb.rd_o !== 5'd0 || wb.write_data_o !== '0) begin
            bad++;
            $display("FAIL reset_state we=%b ret=%0d rd=%0d data=%h want all zero",
                     wb.reg_write_o, wb.retired_o, wb.rd_o, wb.write_data_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        logic [NS-1:0] g;
        exp_t e;
        @(negedge clk_i);
        drive_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        predict(g);
        total++;
        if (wb.src_ready_o !== g) begin
            bad++;
            $display("FAIL single_ready got=%b want=%b", wb.src_ready_o, g);
        end
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        total++;
        if (wb.reg_write_o !== e.we || wb.retired_o !== e.ret || wb.rd_o !== e.rd || wb.write_data_o !== e.data) begin
            bad++;
            $display("FAIL single_write got we=%b rd=%0d data=%h ret=%0d want we=%b rd=%0d data=%h ret=%0d",
                     wb.reg_write_o, wb.rd_o, wb.write_data_o, wb.retired_o, e.we, e.rd, e.data, e.ret);
        end
        // Idle cycle: nothing valid, port must hold the last address/data.
        @(negedge clk_i);
        drive_src(1, 1'b0, 5'd0, 32'h0);
        #1;
        predict(g);
        total++;
        if (wb.src_ready_o !== 3'b000) begin
            bad++;
            $display("FAIL idle_ready got=%b want=000", wb.src_ready_o);
        end
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        total++;
        if (wb.reg_write_o !== 1'b0 || wb.retired_o !== e.ret || wb.rd_o !== 5'd5 || wb.write_data_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL idle_hold got we=%b rd=%0d data=%h ret=%0d want we=0 rd=5 data=deadbeef ret=%0d",
                     wb.reg_write_o, wb.rd_o, wb.write_data_o, wb.retired_o, e.ret);
        end
    endtask

    task automatic test_x0();
        logic [NS-1:0] g;
        exp_t e;
        @(negedge clk_i);
        drive_src(0, 1'b1, 5'd0, 32'h1234);
        #1;
        predict(g);
        total++;
        if (wb.src_ready_o !== g || g !== 3'b001) begin
            bad++;
            $display("FAIL x0_ready got=%b want=001", wb.src_ready_o);
        end
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        total++;
        if (wb.reg_write_o !== 1'b0 || wb.retired_o !== e.ret) begin
            bad++;
            $display("FAIL x0_write got we=%b ret=%0d want we=0 ret=%0d", wb.reg_write_o, wb.retired_o, e.ret);
        end
        @(negedge clk_i);
        drive_src(0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_contention();
        logic [NS-1:0] g;
        exp_t e;
        do_reset();
        @(negedge clk_i);
        drive_src(0, 1'b1, 5'd1, 32'hA0A0_0001);
        drive_src(1, 1'b1, 5'd2, 32'hB0B0_0002);
        drive_src(2, 1'b1, 5'd3, 32'hC0C0_0003);
        for (int c = 0; c < 6; c++) begin
            #1;
            predict(g);
            total++;
            if (wb.src_ready_o !== g || !$onehot(wb.src_ready_o)) begin
                bad++;
                $display("FAIL contention_ready cycle=%0d got=%b want=%b", c, wb.src_ready_o, g);
            end
`ifdef WB_ROUND_ROBIN_EN
            total++;
            if (g !== (NS'(1) << (c % NS))) begin
                bad++;
                $display("FAIL rr_order cycle=%0d got=%b want=%b", c, wb.src_ready_o, NS'(1) << (c % NS));
            end
`endif
            @(posedge clk_i);
            #1;
            e = sb.pop_front();
            total++;
            if (wb.reg_write_o !== e.we || wb.retired_o !== e.ret ||
                (e.we && (wb.rd_o !== e.rd || wb.write_data_o !== e.data))) begin
                bad++;
                $display("FAIL contention_write cycle=%0d got we=%b rd=%0d data=%h ret=%0d want we=%b rd=%0d data=%h ret=%0d",
                         c, wb.reg_write_o, wb.rd_o, wb.write_data_o, wb.retired_o, e.we, e.rd, e.data, e.ret);
            end
            @(negedge clk_i);
`ifndef WB_ROUND_ROBIN_EN
            // Each source drops valid once its result has been taken.
            wb.src_valid_i = wb.src_valid_i & ~g;
            if (wb.src_valid_i == '0) break;
`endif
        end
        wb.src_valid_i = '0;
        total++;
        if (m_ret !== CW'(6) && m_ret !== CW'(3)) begin
            bad++;
            $display("FAIL contention_count model=%0d", m_ret);
        end
        total++;
        if (wb.retired_o !== m_ret) begin
            bad++;
            $display("FAIL contention_retired got=%0d want=%0d", wb.retired_o, m_ret);
        end
    endtask

    task automatic test_back_to_back();
        logic [NS-1:0] g;
        exp_t e;
        do_reset();
        @(negedge clk_i);
        drive_src(0, 1'b1, 5'd7, 32'h1111_1111);
        drive_src(2, 1'b1, 5'd7, 32'h2222_2222);
        for (int c = 0; c < 2; c++) begin
            #1;
            predict(g);
            total++;
            if (wb.src_ready_o !== g) begin
                bad++;
                $display("FAIL b2b_ready cycle=%0d got=%b want=%b", c, wb.src_ready_o, g);
            end
            @(posedge clk_i);
            #1;
            e = sb.pop_front();
            total++;
            if (wb.reg_write_o !== e.we || wb.rd_o !== e.rd || wb.write_data_o !== e.data || wb.retired_o !== e.ret) begin
                bad++;
                $display("FAIL b2b_write cycle=%0d got we=%b rd=%0d data=%h ret=%0d want we=%b rd=%0d data=%h ret=%0d",
                         c, wb.reg_write_o, wb.rd_o, wb.write_data_o, wb.retired_o, e.we, e.rd, e.data, e.ret);
            end
            @(negedge clk_i);
            wb.src_valid_i = wb.src_valid_i & ~g;
        end
        total++;
        if (wb.write_data_o !== 32'h2222_2222 || wb.rd_o !== 5'd7) begin
            bad++;
            $display("FAIL b2b_last_wins got rd=%0d data=%h want rd=7 data=22222222", wb.rd_o, wb.write_data_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [NS-1:0] g;
        exp_t e;
        @(negedge clk_i);
        drive_src(0, 1'b1, 5'd1, 32'h0000_00A1);
        drive_src(1, 1'b1, 5'd2, 32'h0000_00B2);
        drive_src(2, 1'b1, 5'd3, 32'h0000_00C3);
        #1;
        predict(g);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        total++;
        if (wb.reg_write_o !== 1'b1 || wb.retired_o !== e.ret) begin
            bad++;
            $display("FAIL premid_write got we=%b ret=%0d want we=1 ret=%0d", wb.reg_write_o, wb.retired_o, e.ret);
        end
        #1;
        rst_i = 1'b1;
        #1;
        total++;
        if (wb.reg_write_o !== 1'b0 || wb.retired_o !== '0) begin
            bad++;
            $display("FAIL mid_reset got we=%b ret=%0d want we=0 ret=0", wb.reg_write_o, wb.retired_o);
        end
        @(negedge clk_i);
        wb.src_valid_i = '0;
        rst_i = 1'b0;
        m_ptr = 0;
        m_ret = '0;
        sb.delete();
    endtask

    task automatic test_wrap();
        logic [NS-1:0] g;
        exp_t e;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            @(negedge clk_i);
            drive_src(2, 1'b1, 5'd9, XL'(c + 100));
            #1;
            predict(g);
            @(posedge clk_i);
            #1;
            e = sb.pop_front();
            total++;
            if (wb.reg_write_o !== 1'b1 || wb.retired_o !== e.ret || wb.write_data_o !== e.data) begin
                bad++;
                $display("FAIL wrap write=%0d got we=%b ret=%0d data=%h want we=1 ret=%0d data=%h",
                         c + 1, wb.reg_write_o, wb.retired_o, wb.write_data_o, e.ret, e.data);
            end
        end
        @(negedge clk_i);
        wb.src_valid_i = '0;
        total++;
        if (wb.retired_o !== CW'(1)) begin
            bad++;
            $display("FAIL wrap_final got=%0d want=1", wb.retired_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_x0();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
